// File: rtl/ecc_7_pkg.sv
// Shared SECDED(64,57) types, scrubber state encoding and encode/decode helpers.
// data[k] carries syndrome value v(k): non-powers-of-two, v(56)=3 ascending to v(0)=63.
package ecc_7_pkg;

  localparam int DATA_W = 57;
  localparam int CHK_W  = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
    logic              parity;
  } codeword_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CHECK,
    ST_WRITE,
    ST_NEXT
  } scrub_state_t;

  typedef enum logic [1:0] {
    CLS_CLEAN,
    CLS_CORR,
    CLS_UNCORR
  } ecc_class_t;

  function automatic logic [CHK_W-1:0] syn_value(input int k);
    int idx;
    syn_value = '0;
    idx       = DATA_W;
    for (int val = 3; val < 64; val++) begin
      if ((val & (val - 1)) != 0) begin
        idx = idx - 1;
        if (idx == k) syn_value = val[CHK_W-1:0];
      end
    end
  endfunction

  function automatic codeword_t encode(input logic [DATA_W-1:0] data);
    codeword_t cw;
    cw.data  = data;
    cw.check = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (data[k]) cw.check = cw.check ^ syn_value(k);
    end
    cw.parity = ^{data, cw.check};
    return cw;
  endfunction

  function automatic logic [5:0] syn_to_index(input logic [CHK_W-1:0] s);
    syn_to_index = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (syn_value(k) == s) syn_to_index = k[5:0];
    end
  endfunction

endpackage

// File: rtl/ecc_scrubber_7_if.sv
// Shared array port between the scrubber (master) and the array/arbiter (slave).
// Read data is valid the cycle after mem_re.
interface ecc_scrubber_7_if import ecc_7_pkg::*; #(
  parameter int ADDR_W = 8
);
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [CHK_W-1:0]  mem_rcheck;
  logic              mem_rparity;
  logic [DATA_W-1:0] mem_wdata;
  logic [CHK_W-1:0]  mem_wcheck;
  logic              mem_wparity;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata, mem_wcheck, mem_wparity,
    input  mem_rdata, mem_rcheck, mem_rparity
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata, mem_wcheck, mem_wparity,
    output mem_rdata, mem_rcheck, mem_rparity
  );
endinterface

// File: rtl/ecc_classify_7.sv
// Combinational SECDED check of one stored codeword: syndrome, overall parity,
// class and corrected data. Zero latency, no flow control.
module ecc_classify_7 import ecc_7_pkg::*; (
  input  codeword_t         cw,
  output ecc_class_t        cls,
  output logic [DATA_W-1:0] corr_data
);
  codeword_t        recomputed;
  logic [CHK_W-1:0] syndrome;
  logic             parity_err;
  logic             syn_pow2;
  logic [5:0]       bit_idx;

  always_comb begin
    recomputed = encode(cw.data);
    syndrome   = recomputed.check ^ cw.check;
    parity_err = ^cw;
    // Also true for s=0, which covers the lone parity-bit error.
    syn_pow2   = (syndrome & (syndrome - 6'd1)) == '0;
    bit_idx    = syn_to_index(syndrome);
    corr_data  = cw.data;
    cls        = CLS_CLEAN;
    if (parity_err) begin
      cls = CLS_CORR;
      if (!syn_pow2) corr_data[bit_idx] = ~cw.data[bit_idx];
    end else if (syndrome != '0) begin
      cls = CLS_UNCORR;
    end
  end
endmodule

// File: rtl/ecc_scrubber_7.sv
// Background SECDED scrubber: one word per INTERVAL+4 cycles (+1 with writeback), stalls on host_busy.
// ECC_SCRUB_WRITEBACK_EN enables writeback of corrected words; otherwise detect-only.
module ecc_scrubber_7 import ecc_7_pkg::*; #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INTERVAL = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              host_busy,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  ecc_scrubber_7_if.master  mem,
  output logic              err_valid,
  output logic              err_uncorr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       corr_count,
  output logic [15:0]       uncorr_count,
  output logic              pass_done,
  output logic              busy
);
  localparam int                CNT_W     = $clog2(INTERVAL + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  scrub_state_t      state, state_nxt;
  logic [CNT_W-1:0]  ivl_cnt;
  logic [ADDR_W-1:0] scrub_addr;
  codeword_t         rd_cw;
  logic              collide_q;
  logic              collide_now;
  ecc_class_t        cls;
  logic [DATA_W-1:0] corr_data;

  ecc_classify_7 u_classify (
    .cw        (rd_cw),
    .cls       (cls),
    .corr_data (corr_data)
  );

  // A host write to the word in flight makes our copy stale, so the writeback is dropped.
  assign collide_now = host_we && (host_addr == scrub_addr) &&
                       (state inside {ST_READ, ST_WAIT, ST_CHECK, ST_WRITE});

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      ivl_cnt      <= '0;
      scrub_addr   <= '0;
      rd_cw        <= '0;
      collide_q    <= 1'b0;
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_NEXT) begin
        ivl_cnt <= '0;
      end else if (state == ST_IDLE && enable && ivl_cnt != CNT_LAST) begin
        ivl_cnt <= ivl_cnt + CNT_W'(1);
      end

      if (state == ST_NEXT) begin
        collide_q  <= 1'b0;
        scrub_addr <= (scrub_addr == ADDR_LAST) ? '0 : scrub_addr + ADDR_W'(1);
      end else if (collide_now) begin
        collide_q <= 1'b1;
      end

      if (state == ST_WAIT) begin
        rd_cw <= {mem.mem_rdata, mem.mem_rcheck, mem.mem_rparity};
      end

      if (state == ST_CHECK) begin
        if (cls == CLS_CORR && corr_count != 16'hFFFF) corr_count <= corr_count + 16'd1;
        if (cls == CLS_UNCORR && uncorr_count != 16'hFFFF) uncorr_count <= uncorr_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    mem.mem_re = 1'b0;
    mem.mem_we = 1'b0;
    err_valid  = 1'b0;
    err_uncorr = 1'b0;
    pass_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && ivl_cnt == CNT_LAST) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (!host_busy) begin
          mem.mem_re = 1'b1;
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: state_nxt = ST_CHECK;
      ST_CHECK: begin
        err_valid  = (cls != CLS_CLEAN);
        err_uncorr = (cls == CLS_UNCORR);
`ifdef ECC_SCRUB_WRITEBACK_EN
        if (cls == CLS_CORR && !collide_q && !collide_now) state_nxt = ST_WRITE;
        else                                               state_nxt = ST_NEXT;
`else
        state_nxt = ST_NEXT;
`endif
      end
`ifdef ECC_SCRUB_WRITEBACK_EN
      ST_WRITE: begin
        if (collide_q || collide_now) begin
          state_nxt = ST_NEXT;
        end else if (!host_busy) begin
          mem.mem_we = 1'b1;
          state_nxt  = ST_NEXT;
        end
      end
`endif
      ST_NEXT: begin
        pass_done = (scrub_addr == ADDR_LAST);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ECC_SCRUB_WRITEBACK_EN
  codeword_t wr_cw;

  always_ff @(posedge clock) begin
    if (reset)                  wr_cw <= '0;
    else if (state == ST_CHECK) wr_cw <= encode(corr_data);
  end

  assign mem.mem_wdata   = wr_cw.data;
  assign mem.mem_wcheck  = wr_cw.check;
  assign mem.mem_wparity = wr_cw.parity;
`else
  logic unused_detect_only;
  assign unused_detect_only = ^{corr_data, collide_q};

  assign mem.mem_wdata   = '0;
  assign mem.mem_wcheck  = '0;
  assign mem.mem_wparity = 1'b0;
`endif

  assign mem.mem_addr = scrub_addr;
  assign err_addr     = err_valid ? scrub_addr : '0;
  assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_ecc_scrubber_7.sv
// Directed bench for ecc_scrubber_7 with DEPTH=4, INTERVAL=4; word 2 carries the vector under test.
module tb_ecc_scrubber_7;
  localparam int DEPTH    = 4;
  localparam int INTERVAL = 4;
  localparam int AW       = 2;
  localparam int NV       = 7;
`ifdef ECC_SCRUB_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, enable, host_busy, host_we;
  logic [AW-1:0] host_addr;
  logic          err_valid, err_uncorr, pass_done, busy;
  logic [AW-1:0] err_addr;
  logic [15:0]   corr_count, uncorr_count;

  ecc_scrubber_7_if #(.ADDR_W(AW)) mif ();

  ecc_scrubber_7 #(.DEPTH(DEPTH), .ADDR_W(AW), .INTERVAL(INTERVAL)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .host_busy    (host_busy),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .mem          (mif),
    .err_valid    (err_valid),
    .err_uncorr   (err_uncorr),
    .err_addr     (err_addr),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count),
    .pass_done    (pass_done),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Array model: {data, check, parity}, read data one cycle after mem_re.
  logic [63:0] words [DEPTH];
  always @(posedge clock) begin
    if (mif.mem_re) {mif.mem_rdata, mif.mem_rcheck, mif.mem_rparity} <= words[mif.mem_addr];
  end

  int          n_re, n_we, n_err, n_pass;
  int          n_both = 0, n_hb_strobe = 0;
  logic [AW-1:0] err_addr_cap, we_addr_cap;
  logic        err_unc_cap;
  logic [63:0] wr_cap;
  logic        mon_clr = 1'b0;

  always @(negedge clock) begin
    if (mon_clr) begin
      n_re <= 0; n_we <= 0; n_err <= 0; n_pass <= 0;
      err_addr_cap <= '0; we_addr_cap <= '0; err_unc_cap <= 1'b0; wr_cap <= '0;
    end else begin
      if (mif.mem_re) n_re <= n_re + 1;
      if (mif.mem_we) begin
        n_we        <= n_we + 1;
        we_addr_cap <= mif.mem_addr;
        wr_cap      <= {mif.mem_wdata, mif.mem_wcheck, mif.mem_wparity};
      end
      if (err_valid) begin
        n_err        <= n_err + 1;
        err_addr_cap <= err_addr;
        err_unc_cap  <= err_uncorr;
      end
      if (pass_done) n_pass <= n_pass + 1;
    end
    if (mif.mem_re && mif.mem_we) n_both <= n_both + 1;
    if ((mif.mem_re || mif.mem_we) && host_busy) n_hb_strobe <= n_hb_strobe + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; enable = 1'b0; host_busy = 1'b0; host_we = 1'b0; host_addr = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock); #1;
    mon_clr = 1'b0;
  endtask

  // Correctly encoded background words (hand-computed: v(0)=63, v(1)=62, v(56)=3).
  task automatic load_clean();
    words[0] = {57'h0, 6'h00, 1'b0};
    words[1] = {57'h3, 6'h01, 1'b1};
    words[2] = {57'h1, 6'h3F, 1'b1};
    words[3] = {57'h100_0000_0000_0000, 6'h03, 1'b1};
  endtask

  typedef struct {
    string       name;
    logic [56:0] data;
    logic [5:0]  chk;
    logic        par;
    logic        e_err;
    logic        e_unc;
    logic [63:0] e_wr;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [56:0] d, input logic [5:0] c, input logic p,
                              input logic e, input logic u, input logic [63:0] w);
    vec_t v;
    v.name = n; v.data = d; v.chk = c; v.par = p; v.e_err = e; v.e_unc = u; v.e_wr = w;
    return v;
  endfunction

  vec_t vt [NV];

  initial begin
    int t, k_err, re_seen, first_re, second_re;
    logic exp_wr;

    reset = 1'b1; enable = 1'b0; host_busy = 1'b0; host_we = 1'b0; host_addr = '0;
    load_clean();

    vt[0] = mk("clean",     57'h1,                  6'h3F, 1'b1, 1'b0, 1'b0, 64'h0);
    vt[1] = mk("d0_flip",   57'h0,                  6'h3F, 1'b1, 1'b1, 1'b0, {57'h1, 6'h3F, 1'b1});
    vt[2] = mk("d0d1_flip", 57'h3,                  6'h00, 1'b0, 1'b1, 1'b1, 64'h0);
    vt[3] = mk("c3_flip",   57'h1,                  6'h37, 1'b1, 1'b1, 1'b0, {57'h1, 6'h3F, 1'b1});
    vt[4] = mk("par_flip",  57'h1,                  6'h3F, 1'b0, 1'b1, 1'b0, {57'h1, 6'h3F, 1'b1});
    vt[5] = mk("d56_flip",  57'h100_0000_0000_0001, 6'h3F, 1'b1, 1'b1, 1'b0, {57'h1, 6'h3F, 1'b1});
    vt[6] = mk("c0c1_flip", 57'h0,                  6'h03, 1'b0, 1'b1, 1'b1, 64'h0);

    do_reset();
    @(negedge clock);
    check("rst_strobes", {busy, mif.mem_re, mif.mem_we, err_valid, err_uncorr, pass_done}, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_counts", {corr_count, uncorr_count}, 0);
    check("rst_wr_bus", {mif.mem_wdata, mif.mem_wcheck, mif.mem_wparity}, 0);

    // One full pass per vector.
    for (int i = 0; i < NV; i++) begin
      load_clean();
      words[2] = {vt[i].data, vt[i].chk, vt[i].par};
      do_reset();
      clear_mon();
      enable = 1'b1;
      t = 0;
      while (n_pass == 0 && t < 200) begin
        @(posedge clock); #1;
        t++;
      end
      enable = 1'b0;
      exp_wr = WB && vt[i].e_err && !vt[i].e_unc;
      check({vt[i].name, "_reads"},      n_re, 4);
      check({vt[i].name, "_writes"},     n_we, exp_wr ? 1 : 0);
      check({vt[i].name, "_pass_done"},  n_pass, 1);
      check({vt[i].name, "_err_events"}, n_err, vt[i].e_err ? 1 : 0);
      check({vt[i].name, "_err_uncorr"}, err_unc_cap, vt[i].e_unc);
      check({vt[i].name, "_err_addr"},   err_addr_cap, vt[i].e_err ? 2 : 0);
      check({vt[i].name, "_wr_word"},    wr_cap, exp_wr ? vt[i].e_wr : 64'h0);
      check({vt[i].name, "_wr_addr"},    we_addr_cap, exp_wr ? 2 : 0);
      check({vt[i].name, "_corr_cnt"},   corr_count, (vt[i].e_err && !vt[i].e_unc) ? 1 : 0);
      check({vt[i].name, "_uncorr_cnt"}, uncorr_count, vt[i].e_unc ? 1 : 0);
    end

    // host_busy held through 10 READ cycles: read moves from cycle 4 to 14.
    load_clean();
    do_reset();
    clear_mon();
    host_busy = 1'b1; enable = 1'b1;
    re_seen = 0; first_re = 0; second_re = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clock); #1;
      host_busy = (k < 14);
      @(negedge clock);
      if (k == 9) check("stall_busy", busy, 1);
      if (mif.mem_re) begin
        re_seen++;
        if (re_seen == 1) first_re = k;
        if (re_seen == 2) begin
          second_re = k;
          check("stall_second_addr", mif.mem_addr, 1);
        end
      end
    end
    check("stall_first_re", first_re, 14);
    check("stall_second_re", second_re, 22);
    check("stall_re_count", re_seen, 2);

    // Correctable word at addr 0; host writes addr 0 in the WRITE cycle.
    load_clean();
    words[0] = {57'h0, 6'h3F, 1'b1};
    do_reset();
    clear_mon();
    enable = 1'b1;
    k_err = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      host_we = (k == 7); host_addr = '0;
      @(negedge clock);
      if (err_valid) begin
        k_err = k;
        check("coll_err_addr", err_addr, 0);
        check("coll_err_uncorr", err_uncorr, 0);
      end
    end
    @(posedge clock); #1;
    host_we = 1'b0;
    check("coll_err_cycle", k_err, 6);
    check("coll_no_write", n_we, 0);
    check("coll_corr_cnt", corr_count, 1);

    // enable drops in WAIT: word completes, parks, counter holds at 0 until re-enabled.
    load_clean();
    do_reset();
    clear_mon();
    enable = 1'b1;
    re_seen = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clock); #1;
      if (k == 5)  enable = 1'b0;
      if (k == 30) enable = 1'b1;
      @(negedge clock);
      if (k == 10) check("park_busy", busy, 0);
      if (mif.mem_re) begin
        re_seen++;
        if (re_seen == 2) begin
          check("resume_re_cycle", k, 34);
          check("resume_addr", mif.mem_addr, 1);
        end
      end
    end
    check("park_re_count", re_seen, 2);

    // Reset during WAIT of word 1: back to IDLE at address 0.
    load_clean();
    do_reset();
    clear_mon();
    enable = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clock); #1;
      if (k == 13) reset = 1'b1;
      if (k == 14) reset = 1'b0;
      @(negedge clock);
      if (k == 12) check("pre_rst_read_addr", {mif.mem_re, mif.mem_addr}, {1'b1, 2'd1});
      if (k == 14) begin
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", mif.mem_addr, 0);
      end
      if (k == 18) check("post_rst_read_addr", {mif.mem_re, mif.mem_addr}, {1'b1, 2'd0});
    end
    enable = 1'b0;
    @(posedge clock); #1;

    check("strobes_together", n_both, 0);
    check("strobe_during_host_busy", n_hb_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ecc_scrubber_7.md
# ecc_scrubber_7

Background scrubber for SECDED-protected arrays using the 57-bit data / 6-check-bit / 1-overall-parity codeword. It walks the array one word at a time, reads the stored codeword through a shared array port, and classifies the word as clean, correctable or uncorrectable. Correctable words are re-encoded and written back. It sits beside the functional read/write path, yields the array port to the host, and exposes error counters and an error event to the status logic.

## Interface
- DEPTH, 256, number of words in the scrubbed array
- ADDR_W, $clog2(DEPTH), address width
- INTERVAL, 1024, idle cycles between consecutive word scrubs (≥1)

- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scrubbing allowed; deassert finishes current word, then parks
- host_busy  in  1  host owns the array port this cycle; scrubber must not drive mem_re/mem_we
- host_we, host_addr  in  1, ADDR_W  host write strobe/address (collision detection)
- mem_re, mem_we  out  1  array read/write strobes
- mem_addr  out  ADDR_W  array address
- mem_rdata, mem_rcheck, mem_rparity  in  57, 6, 1  stored codeword, valid the cycle after mem_re
- mem_wdata, mem_wcheck, mem_wparity  out  57, 6, 1  re-encoded codeword for writeback
- err_valid  out  1  one-cycle pulse: non-clean word found
- err_uncorr  out  1  qualifies err_valid: 1 = double error
- err_addr  out  ADDR_W  address of the reported word
- corr_count, uncorr_count  out  16 each  saturating event counters
- pass_done  out  1  one-cycle pulse after the last address is processed
- busy  out  1  FSM not in IDLE

## Operation
- Code: data[k] maps to syndrome value v(k), where v(56)=3, and v ascends through the non-power-of-two values up to v(0)=63. check[i] = XOR of the data[k] with bit i of v(k) set. parity = XOR of all 57 data bits and 6 check bits.
- Syndrome s = recomputed check XOR stored check. p = XOR of all 64 stored bits.
- Classification:
  - s=0, p=0: clean.
  - s≠0, p=1: single error. If s is a power of two, the check bit is in error. Otherwise flip data[k] where v(k)=s.
  - s=0, p=1: parity-bit error, correctable.
  - s≠0, p=0: uncorrectable.
- FSM states:
  - IDLE: the interval counter runs while enable=1. At INTERVAL-1 it moves to READ.
  - READ: asserts mem_re, mem_addr=scrub address. It holds in READ while host_busy=1.
  - WAIT: samples the mem_r* bus.
  - CHECK: registers the classification and pulses err_valid if the word is non-clean. Correctable goes to WRITE. Clean or uncorrectable goes to NEXT.
  - WRITE: asserts mem_we with the corrected data re-encoded (fresh check and parity). It holds in WRITE while host_busy=1.
  - NEXT: increments the address. On wrap DEPTH-1→0 it pulses pass_done. It clears the interval counter and goes to IDLE.
- Collision: if host_we=1 with host_addr equal to the scrub address in any cycle from the READ issue through WRITE, the writeback is cancelled and the FSM goes straight to NEXT. The count and err_valid still reflect what was read.
- Counters increment in CHECK and saturate at 16'hFFFF. Reset clears them.
- If enable drops mid-word, the word completes. The FSM parks in IDLE, and the interval counter holds.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - The scrub address and interval counter are 0.
  - Reset mid-operation drops any pending write, so mem_we=0 from the next edge.
- Minimum cycles per word: INTERVAL + 4 for a clean word, INTERVAL + 5 with writeback. Each cycle of host_busy stall adds one cycle.
- mem_re and mem_we are asserted only in READ/WRITE with host_busy=0, each for exactly one cycle per word, and never together.
- err_valid, err_uncorr and err_addr are valid in the same cycle, the CHECK cycle.

## Configuration
- ECC_SCRUB_WRITEBACK_EN defined: the block works as above.
- Undefined: detect-only mode.
  - The WRITE state is removed and mem_we is tied 0.
  - The mem_w* outputs are tied 0.
  - Counters and events behave identically.

## Structure
- Package ecc_7_pkg holds:
  - DATA_W=57 and CHK_W=6.
  - The codeword struct typedef.
  - The scrubber state enum.
  - An encode function (data→check, parity).
  - A syndrome→data-bit-index function.
- Sub-module ecc_classify_7: combinational syndrome, parity, class and corrected data from a codeword. The FSM instantiates it once; the package encode function is used for writeback.

## Test plan
- DEPTH=4, INTERVAL=4, all words correctly encoded → 4 reads, no mem_we, pass_done once, both counts 0.
- data[0] flipped at addr 2 (s=63, p=1) → err_valid with err_uncorr=0, err_addr=2; mem_we at addr 2 with the original data and check; corr_count=1.
- data[0] and data[1] flipped (s=1, p=0) → err_uncorr=1, no mem_we, uncorr_count=1.
- Only check[3] flipped (s=8, p=1) → writeback of the re-encoded codeword with unchanged data, corr_count=1.
- Correctable word, host_we to the same address during WRITE → no scrubber mem_we, corr_count=1. host_busy held 10 cycles in READ → mem_re delayed 10 cycles, issued once.
- Macro undefined, data[0] flipped → corr_count=1, mem_we never asserted. Reset pulsed in WAIT → FSM returns to IDLE with address 0.
